// File: rtl/knot_resp_misr_if.sv
// -----------------------------------------------------------------------------
// knot_resp_misr_if
// Bundles the capture-control, response and status signals of the response
// compactor.
//   master : drives start/win_len/y_in/y_valid/golden, observes status
//   slave  : the compactor itself
// Signals:
//   start      begin/restart a capture window
//   win_len    window length in samples, sampled on start
//   y_in       response vector y1..y9 (y1 = bit 0)
//   y_valid    y_in carries a sample this cycle
//   golden     expected signature, sampled on the edge entering DONE
//   busy       capture window open
//   done       window complete, results frozen
//   match      final signature equalled golden (valid while done)
//   sig_out    current MISR contents
//   sample_cnt samples accepted in the current window
//   zero_cnt   accepted all-zero samples (saturating)
// -----------------------------------------------------------------------------
interface knot_resp_misr_if #(
  parameter int WIDTH = 9,
  parameter int SIG_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] win_len;
  logic [WIDTH-1:0] y_in;
  logic             y_valid;
  logic [SIG_W-1:0] golden;
  logic             busy;
  logic             done;
  logic             match;
  logic [SIG_W-1:0] sig_out;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] zero_cnt;

  modport master (
    output start, win_len, y_in, y_valid, golden,
    input  busy, done, match, sig_out, sample_cnt, zero_cnt
  );

  modport slave (
    input  start, win_len, y_in, y_valid, golden,
    output busy, done, match, sig_out, sample_cnt, zero_cnt
  );
endinterface

// File: rtl/knot_resp_misr.sv
// -----------------------------------------------------------------------------
// knot_resp_misr
// Response compactor for knot-style FSM benchmarks. Folds a programmable
// window of y1..y9 samples into a MISR, counts all-zero samples, and flags
// whether the final signature equals a golden value.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  synchronous active-low reset
//   bus  knot_resp_misr_if.slave (control, response vector, status)
// States: IDLE -> CAPTURE -> DONE; start restarts from any state, and a
// zero-length window goes straight to DONE.
// -----------------------------------------------------------------------------
module knot_resp_misr #(
  parameter int               WIDTH = 9,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] TAPS  = 16'hB400,
  parameter logic [SIG_W-1:0] SEED  = 16'h0000,
  parameter int               CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  knot_resp_misr_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_zero_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_busy;
  logic             r_done;
  logic             r_match;

  logic             w_fb;
  logic [SIG_W-1:0] w_y_ext;
  logic [SIG_W-1:0] w_sig_next;
  logic [CNT_W-1:0] w_sample_next;
  logic             w_accept;

  // MISR step: shift left with tap feedback into bit 0, then fold the sample in.
  assign w_fb          = ^(r_sig & TAPS);
  assign w_y_ext       = SIG_W'(bus.y_in);
  assign w_sig_next    = {r_sig[SIG_W-2:0], w_fb} ^ w_y_ext;
  assign w_sample_next = r_sample_cnt + 1'b1;

  // start has priority over a sample on the same edge.
  assign w_accept = (r_state == S_CAPTURE) && bus.y_valid && !bus.start;

  // NOTE: all state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_sig        <= SEED;
      r_sample_cnt <= '0;
      r_zero_cnt   <= '0;
      r_len        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_match      <= 1'b0;
    end else if (bus.start) begin
      r_len        <= bus.win_len;
      r_sig        <= SEED;
      r_sample_cnt <= '0;
      r_zero_cnt   <= '0;
      if (bus.win_len == '0) begin
        // Empty window: the signature is just the seed.
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_match <= (SEED == bus.golden);
      end else begin
        r_state <= S_CAPTURE;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_match <= 1'b0;
      end
    end else if (w_accept) begin
      r_sig        <= w_sig_next;
      r_sample_cnt <= w_sample_next;
      if (bus.y_in == '0 && r_zero_cnt != '1) begin
        r_zero_cnt <= r_zero_cnt + 1'b1;
      end
      if (w_sample_next == r_len) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_match <= (w_sig_next == bus.golden);
      end
    end
  end

  // Status flags come straight from registers: no input-to-output path.
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.match      = r_match;
  assign bus.sig_out    = r_sig;
  assign bus.sample_cnt = r_sample_cnt;
  assign bus.zero_cnt   = r_zero_cnt;

endmodule

// File: tb/tb_knot_resp_misr.sv
// -----------------------------------------------------------------------------
// tb_knot_resp_misr
// Directed bench for knot_resp_misr. u_dut uses the default SEED; u_dut_fb
// uses SEED = 16'h8000 so the tap feedback path is exercised on the first
// sample. Inputs change #1 after a posedge; outputs are read at that point,
// after the edge has settled.
// -----------------------------------------------------------------------------
module tb_knot_resp_misr;

  logic clk;
  logic rst;

  int checks;
  int failures;

  knot_resp_misr_if #(.WIDTH(9), .SIG_W(16), .CNT_W(16)) bus0 ();
  knot_resp_misr_if #(.WIDTH(9), .SIG_W(16), .CNT_W(16)) bus1 ();

  knot_resp_misr #(
    .WIDTH(9), .SIG_W(16), .TAPS(16'hB400), .SEED(16'h0000), .CNT_W(16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  knot_resp_misr #(
    .WIDTH(9), .SIG_W(16), .TAPS(16'hB400), .SEED(16'h8000), .CNT_W(16)
  ) u_dut_fb (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    rst          = 1'b0;
    bus0.start   = 1'b0;
    bus0.win_len = '0;
    bus0.y_in    = '0;
    bus0.y_valid = 1'b0;
    bus0.golden  = '0;
    bus1.start   = 1'b0;
    bus1.win_len = '0;
    bus1.y_in    = '0;
    bus1.y_valid = 1'b0;
    bus1.golden  = '0;

    // ---- Reset then idle ----
    bus0.y_valid = 1'b1; bus0.y_in = 9'h0AA;
    step();
    bus0.y_valid = 1'b0;
    step();
    check("rst_sig",    32'(bus0.sig_out),    32'h0000);
    check("rst_cnt",    32'(bus0.sample_cnt), 32'd0);
    check("rst_zero",   32'(bus0.zero_cnt),   32'd0);
    check("rst_busy",   32'(bus0.busy),       32'd0);
    check("rst_done",   32'(bus0.done),       32'd0);
    check("rst_match",  32'(bus0.match),      32'd0);
    check("rst_sig_fb", 32'(bus1.sig_out),    32'h8000);

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.y_valid = i[0];
      bus0.y_in    = 9'h000;
      step();
    end
    bus0.y_valid = 1'b0;
    check("idle_sig",  32'(bus0.sig_out),    32'h0000);
    check("idle_cnt",  32'(bus0.sample_cnt), 32'd0);
    check("idle_zero", 32'(bus0.zero_cnt),   32'd0);
    check("idle_busy", 32'(bus0.busy),       32'd0);

    // ---- Single sample; a sample on the start edge is not accepted ----
    bus0.start = 1'b1; bus0.win_len = 16'd1; bus0.golden = 16'h01FF;
    bus0.y_valid = 1'b1; bus0.y_in = 9'h1FF;
    step();
    bus0.start = 1'b0;
    check("s1_busy",     32'(bus0.busy),       32'd1);
    check("s1_cnt0",     32'(bus0.sample_cnt), 32'd0);
    check("s1_sig0",     32'(bus0.sig_out),    32'h0000);
    step();
    check("s1_sig",   32'(bus0.sig_out),    32'h01FF);
    check("s1_done",  32'(bus0.done),       32'd1);
    check("s1_match", 32'(bus0.match),      32'd1);
    check("s1_busy0", 32'(bus0.busy),       32'd0);
    check("s1_cnt",   32'(bus0.sample_cnt), 32'd1);
    check("s1_zero",  32'(bus0.zero_cnt),   32'd0);
    // DONE ignores further samples.
    bus0.y_in = 9'h055;
    step();
    step();
    bus0.y_valid = 1'b0;
    check("s1_hold_sig", 32'(bus0.sig_out),    32'h01FF);
    check("s1_hold_cnt", 32'(bus0.sample_cnt), 32'd1);
    check("s1_hold_done", 32'(bus0.done),      32'd1);

    // ---- Two samples with a valid gap ----
    bus0.start = 1'b1; bus0.win_len = 16'd2; bus0.golden = 16'h0003;
    step();
    bus0.start = 1'b0;
    check("s2_match_clr", 32'(bus0.match), 32'd0);
    bus0.y_valid = 1'b1; bus0.y_in = 9'h001;
    step();
    check("s2_sig1", 32'(bus0.sig_out), 32'h0001);
    bus0.y_valid = 1'b0;
    step(); step(); step();
    check("s2_gap_sig",  32'(bus0.sig_out),    32'h0001);
    check("s2_gap_cnt",  32'(bus0.sample_cnt), 32'd1);
    check("s2_gap_busy", 32'(bus0.busy),       32'd1);
    bus0.y_valid = 1'b1; bus0.y_in = 9'h000;
    step();
    bus0.y_valid = 1'b0;
    check("s2_sig2",  32'(bus0.sig_out),    32'h0002);
    check("s2_zero",  32'(bus0.zero_cnt),   32'd1);
    check("s2_done",  32'(bus0.done),       32'd1);
    check("s2_match", 32'(bus0.match),      32'd0);
    check("s2_cnt",   32'(bus0.sample_cnt), 32'd2);

    // ---- Feedback path (SEED = 0x8000): fb=1, shifted value 0x0001 ----
    bus1.start = 1'b1; bus1.win_len = 16'd1; bus1.golden = 16'h0001;
    step();
    bus1.start = 1'b0;
    check("fb_seed", 32'(bus1.sig_out), 32'h8000);
    bus1.y_valid = 1'b1; bus1.y_in = 9'h000;
    step();
    bus1.y_valid = 1'b0;
    check("fb_sig",   32'(bus1.sig_out),  32'h0001);
    check("fb_zero",  32'(bus1.zero_cnt), 32'd1);
    check("fb_done",  32'(bus1.done),     32'd1);
    check("fb_match", 32'(bus1.match),    32'd1);

    // ---- Zero-length window ----
    bus0.start = 1'b1; bus0.win_len = 16'd0; bus0.golden = 16'h0000;
    step();
    bus0.start = 1'b0;
    check("z_done",  32'(bus0.done),    32'd1);
    check("z_match", 32'(bus0.match),   32'd1);
    check("z_busy",  32'(bus0.busy),    32'd0);
    check("z_sig",   32'(bus0.sig_out), 32'h0000);
    bus0.y_valid = 1'b1; bus0.y_in = 9'h003;
    step();
    bus0.y_valid = 1'b0;
    check("z_busy2", 32'(bus0.busy),       32'd0);
    check("z_cnt",   32'(bus0.sample_cnt), 32'd0);
    bus0.start = 1'b1; bus0.win_len = 16'd0; bus0.golden = 16'h1234;
    step();
    bus0.start = 1'b0;
    check("z_nomatch", 32'(bus0.match), 32'd0);
    check("z_done2",   32'(bus0.done),  32'd1);

    // ---- Restart during CAPTURE after 3 accepted samples ----
    bus0.start = 1'b1; bus0.win_len = 16'd5;
    step();
    bus0.start = 1'b0;
    bus0.y_valid = 1'b1; bus0.y_in = 9'h000; step();
    bus0.y_in = 9'h010; step();
    bus0.y_in = 9'h000; step();
    check("r_cnt3",  32'(bus0.sample_cnt), 32'd3);
    check("r_zero2", 32'(bus0.zero_cnt),   32'd2);
    bus0.start = 1'b1; bus0.win_len = 16'd2; bus0.golden = 16'h0003;
    bus0.y_in = 9'h1FF;
    step();
    bus0.start = 1'b0; bus0.y_valid = 1'b0;
    check("r_cnt0",  32'(bus0.sample_cnt), 32'd0);
    check("r_zero0", 32'(bus0.zero_cnt),   32'd0);
    check("r_sig0",  32'(bus0.sig_out),    32'h0000);
    check("r_busy",  32'(bus0.busy),       32'd1);
    bus0.y_valid = 1'b1; bus0.y_in = 9'h003;
    step();
    check("r_sig1",  32'(bus0.sig_out), 32'h0003);
    check("r_busy1", 32'(bus0.busy),    32'd1);
    bus0.y_in = 9'h005;
    step();
    bus0.y_valid = 1'b0;
    check("r_sig2",  32'(bus0.sig_out),    32'h0003);
    check("r_cnt2",  32'(bus0.sample_cnt), 32'd2);
    check("r_done",  32'(bus0.done),       32'd1);
    check("r_match", 32'(bus0.match),      32'd1);

    // ---- Reset mid-window ----
    bus0.start = 1'b1; bus0.win_len = 16'd4;
    step();
    bus0.start = 1'b0;
    bus0.y_valid = 1'b1; bus0.y_in = 9'h007;
    step();
    check("m_cnt1", 32'(bus0.sample_cnt), 32'd1);
    check("m_busy", 32'(bus0.busy),       32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1; bus0.y_valid = 1'b0;
    check("m_busy0", 32'(bus0.busy),       32'd0);
    check("m_done0", 32'(bus0.done),       32'd0);
    check("m_match", 32'(bus0.match),      32'd0);
    check("m_sig",   32'(bus0.sig_out),    32'h0000);
    check("m_cnt0",  32'(bus0.sample_cnt), 32'd0);
    check("m_zero",  32'(bus0.zero_cnt),   32'd0);
    bus0.y_valid = 1'b1; bus0.y_in = 9'h00F;
    step();
    step();
    bus0.y_valid = 1'b0;
    check("m_idle_sig", 32'(bus0.sig_out),    32'h0000);
    check("m_idle_cnt", 32'(bus0.sample_cnt), 32'd0);
    check("m_idle_busy", 32'(bus0.busy),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knot_resp_misr.md
Name: knot_resp_misr

Overview:
- Downstream response compactor for the knot-style FSM benchmarks.
- Consumes the 9-bit output vector y1..y9 of the FSM under test and folds a programmable window of samples into a multiple-input signature register (MISR).
- Counts all-zero output cycles, the signature of payload-suppressed outputs.
- Compares the final signature against a golden value, so locked, unlocked and trojan-active runs are distinguishable from one flag.

Parameters:
- WIDTH, 9, width of the response vector (y1 = bit 0 … y9 = bit 8).
- SIG_W, 16, MISR width; must be ≥ WIDTH.
- TAPS, 16'hB400, feedback tap mask (bits 15,13,12,10).
- SEED, 16'h0000, MISR value loaded on start.
- CNT_W, 16, width of the window length and the counters.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin/restart a capture window.
- win_len  input  CNT_W  number of valid samples to compact; sampled on start.
- y_in  input  WIDTH  response vector from the FSM under test.
- y_valid  input  1  y_in is a sample this cycle.
- golden  input  SIG_W  expected signature; sampled on the edge entering DONE.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE.
- match  output  1  final signature equalled golden; valid while done=1.
- sig_out  output  SIG_W  current MISR contents.
- sample_cnt  output  CNT_W  samples accepted in the current window.
- zero_cnt  output  CNT_W  accepted samples with y_in == 0; saturates at all-ones.

Behaviour:
- Reset (rst=0 at posedge):
  - state = IDLE.
  - busy=0, done=0, match=0.
  - sig_out=SEED, sample_cnt=0, zero_cnt=0, latched length=0.
  - Reset overrides everything, including mid-window.
- States: IDLE, CAPTURE, DONE.
- Start from IDLE or DONE (start=1):
  - Latch win_len.
  - sig_out ← SEED; sample_cnt ← 0; zero_cnt ← 0; match ← 0.
  - Next state is CAPTURE, or DONE if win_len == 0. For win_len == 0, match is computed from SEED vs golden.
  - A sample present on the start edge is not accepted.
- Start in CAPTURE: abort and restart with identical effect. y_valid on that edge is ignored.
- Accept rule: a sample is accepted on a posedge where state == CAPTURE, y_valid == 1 and start == 0.
- MISR update per accepted sample:
  - fb = XOR-reduce(sig_out & TAPS).
  - sig_next = {sig_out[SIG_W-2:0], fb} XOR zero-extended y_in.
  - sample_cnt += 1.
  - If y_in == 0, zero_cnt += 1 unless already all-ones.
- Cycles without y_valid hold all registers. There is no timeout.
- Window end: when the accepted sample makes sample_cnt equal the latched length:
  - State goes to DONE on that same edge.
  - sig_out = sig_next.
  - match ← (sig_next == golden).
  - done = 1 from the following cycle, i.e. one cycle after the last sample.
- DONE:
  - Holds sig_out, the counters and match indefinitely.
  - y_valid is ignored.
  - Only start or reset leave DONE.
- IDLE: y_valid is ignored.
- Output timing: busy, done and match are registered, decoded from state/registers, with no combinational path from inputs.
- Simultaneous events:
  - rst beats start.
  - start beats y_valid.
  - Last-sample completion and a same-edge start cannot coincide, because start blocks acceptance.

Test Plan:
- Reset then idle:
  - Stimulus: rst=0 for 2 cycles, then rst=1; y_valid toggling.
  - Required: sig_out=0x0000, counters 0, busy=done=match=0, unchanged.
- Single sample:
  - Stimulus: start with win_len=1, golden=0x01FF; next cycle y_in=0x1FF, y_valid=1.
  - Required: sig_out=0x01FF; done=1 and match=1 one cycle later; sample_cnt=1; zero_cnt=0.
- Two samples with a valid gap:
  - Stimulus: win_len=2, golden=0x0003; samples 0x001, idle 3 cycles, then 0x000.
  - Required: sig_out=0x0001 then 0x0002; zero_cnt=1; done=1; match=0.
- Feedback path:
  - Stimulus: SEED overridden to 16'h8000, win_len=1, y_in=0x000.
  - Required: sig_out=0x0001 (fb=1); zero_cnt=1.
- Zero window and restart:
  - Zero window: win_len=0, golden=SEED. Required: done=1 and match=1 next cycle; busy never asserts.
  - Restart: start during CAPTURE after 3 accepted samples. Required: counters back to 0, sig_out=SEED, window recounts from scratch.
- Reset mid-window:
  - Stimulus: rst=0 while busy=1.
  - Required: next cycle IDLE with all outputs at reset values; later y_valid is ignored until start.
